mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multi-cycle MIPS control unit that sequences the shared datapath: program counter, instruction register, ALU and register file.
- Each instruction is walked through FETCH/DECODE/EXECUTE/MEM/WRITEBACK states.
- Drives the PC-update controls (PCEnable, PCSource) and the 4-bit ALU Control, with Zero as the branch input.
- Stalls on a memory-ready handshake.
- Sits between the instruction register and the datapath top.

Parameters:
- RESET_VECTOR_SEL, 0, PCSource value held during the reset state (selects the reset path in the PC mux).
- ALU_W, 4, width of the ALU Control output.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- OpCode  in  6  instruction bits [31:26] from the IR
- Funct  in  6  instruction bits [5:0] from the IR
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory completes the access this cycle
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load the instruction register
- PCEnable  out  1  PC register load enable
- PCSource  out  2  PC mux select: 00 = ALU result, 01 = ALUOut (branch), 10 = jump target
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- Control  out  ALU_W  ALU operation
- RegDst  out  1  register-file destination: 0 = rt, 1 = rd
- MemtoReg  out  1  register-file write data: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register-file write enable
- IllegalOp  out  1  sticky flag: unsupported opcode/funct seen

Behaviour:
- Reset: synchronous, active-high. On a clock edge with Reset=1, state becomes S_RESET and IllegalOp is cleared. Reset mid-instruction aborts it; no strobe is asserted in the reset cycle or in S_RESET.
- S_RESET: all strobes 0, PCSource=RESET_VECTOR_SEL. Next state is S_FETCH.
- Outputs are Moore-decoded from the state, except that the memory-completion strobes are qualified by MemReady.
- ALU Control encoding: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- S_FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, Control=0010, PCSource=00.
  - IRWrite and PCEnable assert only in a cycle with MemReady=1; the state then advances to S_DECODE.
  - While MemReady=0, hold in S_FETCH with IRWrite=PCEnable=0.
- S_DECODE: ALUSrcA=0, ALUSrcB=11, Control=0010 (branch target into ALUOut). Dispatch on OpCode:
  - 000000 (R-type) -> S_RTYPE
  - 100011 (lw) or 101011 (sw) -> S_MEMADDR
  - 000100 (beq) or 000101 (bne) -> S_BRANCH
  - 001000 (addi) -> S_ADDI
  - 000010 (j) -> S_JUMP
  - any other OpCode: set IllegalOp, go to S_FETCH.
- S_MEMADDR: ALUSrcA=1, ALUSrcB=10, Control=0010. Next state is S_MEMRD for lw, S_MEMWR for sw.
- S_MEMRD: MemRead=1, IorD=1. Wait for MemReady, then go to S_MEMWB.
- S_MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next state is S_FETCH.
- S_MEMWR: MemWrite=1, IorD=1. Wait for MemReady, then go to S_FETCH.
- S_RTYPE: ALUSrcA=1, ALUSrcB=00, Control taken from the Funct decode:
  - 100000 -> 0010 (add); 100010 -> 0110 (sub); 100100 -> 0000 (and); 100101 -> 0001 (or); 101010 -> 0111 (slt).
  - Any other Funct: set IllegalOp, Control=0010, go to S_FETCH without write-back.
  - Otherwise next state is S_RTYPE_WB.
- S_RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0. Next state is S_FETCH.
- S_BRANCH: ALUSrcA=1, ALUSrcB=00, Control=0110, PCSource=01.
  - PCEnable = Zero for beq, ~Zero for bne, evaluated the same cycle.
  - Next state is S_FETCH.
- S_ADDI: ALUSrcA=1, ALUSrcB=10, Control=0010. Next state is S_ADDI_WB.
- S_ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0. Next state is S_FETCH.
- S_JUMP: PCSource=10, PCEnable=1. Next state is S_FETCH.
- Latency with MemReady tied to 1, in cycles:
  - j: 3 (FETCH, DECODE, JUMP)
  - beq/bne: 3
  - R-type, addi, sw: 4
  - lw: 5
  - Each MemReady=0 cycle adds exactly one cycle.
- Every unlisted output is 0 in every state.
- At most one of MemRead/MemWrite is high in any cycle.
- IllegalOp is sticky until Reset.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings (4-bit localparams S_RESET through S_JUMP)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - funct constants
  - ALU Control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT)
- Sub-module mips_alu_decode: combinational Funct -> Control plus a valid flag. It is reused by the single-cycle datapath.

Test Plan:
- Reset=1 for 2 cycles, then 0 -> all strobes 0 during reset and in S_RESET; first S_FETCH on the 2nd cycle after release, with MemRead=1, IorD=0, Control=0010.
- OpCode=000100, Zero=0, MemReady=1 -> PCEnable pulses only in FETCH (cycle 1); cycle 3 has PCSource=01, Control=0110, PCEnable=0. Repeat with Zero=1 -> PCEnable=1 in cycle 3.
- OpCode=100011, MemReady low for 2 cycles in S_MEMRD -> 7 cycles total; RegWrite=1 and MemtoReg=1 in exactly one cycle.
- OpCode=000000, Funct=100010 -> Control=0110 in S_RTYPE, then RegWrite=1 and RegDst=1; Funct=111111 -> IllegalOp=1, no RegWrite, back to FETCH.
- OpCode=000010 -> 3 cycles, PCSource=10 and PCEnable=1 in cycle 3; OpCode=111111 -> IllegalOp set, held through the next instruction, cleared only by Reset.
- Reset asserted in S_MEMWR while MemReady=0 -> no MemWrite/RegWrite after the edge; S_RESET, then FETCH resumes.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS control path: state encodings, opcodes, funct codes, ALU codes.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W    = 4;
    localparam int unsigned OP_W       = 6;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned ALU_CODE_W = 4;

    // Controller states; the explicit values keep the encoding stable across tools.
    typedef enum logic [STATE_W-1:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE    = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDI     = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational R-type Funct to ALU Control decode; also used by the single-cycle datapath.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [FUNCT_W-1:0]    funct,
    output logic [ALU_CODE_W-1:0] control_c,
    output logic                  valid_c
);

    // Unsupported funct codes fall back to ADD with valid_c low.
    always_comb begin
        control_c = ALU_ADD;
        valid_c   = 1'b1;
        case (funct)
            FN_ADD:  control_c = ALU_ADD;
            FN_SUB:  control_c = ALU_SUB;
            FN_AND:  control_c = ALU_AND;
            FN_OR:   control_c = ALU_OR;
            FN_SLT:  control_c = ALU_SLT;
            default: valid_c   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit: sequences fetch, decode, execute, memory and write-back.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [1:0]  RESET_VECTOR_SEL = 2'b00,
    parameter int unsigned ALU_W            = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCEnable,
    output logic [1:0]       PCSource,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [ALU_W-1:0] Control,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             IllegalOp
);

    state_t                state;
    state_t                state_nxt;
    logic                  illegal_set_c;
    logic [ALU_CODE_W-1:0] alu_code;
    logic [ALU_CODE_W-1:0] funct_ctrl_c;
    logic                  funct_valid_c;

    mips_alu_decode u_alu_decode (
        .funct     (Funct),
        .control_c (funct_ctrl_c),
        .valid_c   (funct_valid_c)
    );

    // State register and sticky illegal-instruction flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_RESET;
            IllegalOp <= 1'b0;
        end else begin
            state <= state_nxt;
            if (illegal_set_c) begin
                IllegalOp <= 1'b1;
            end
        end
    end

    // Next-state logic; memory states hold until MemReady.
    always_comb begin
        state_nxt     = state;
        illegal_set_c = 1'b0;
        case (state)
            S_RESET:    state_nxt = S_FETCH;
            S_FETCH:    if (MemReady) state_nxt = S_DECODE;
            S_DECODE: begin
                case (OpCode)
                    OP_RTYPE:      state_nxt = S_RTYPE;
                    OP_LW, OP_SW:  state_nxt = S_MEMADDR;
                    OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
                    OP_ADDI:       state_nxt = S_ADDI;
                    OP_J:          state_nxt = S_JUMP;
                    default: begin
                        state_nxt     = S_FETCH;
                        illegal_set_c = 1'b1;
                    end
                endcase
            end
            S_MEMADDR:  state_nxt = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (MemReady) state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWR:    if (MemReady) state_nxt = S_FETCH;
            S_RTYPE: begin
                if (funct_valid_c) begin
                    state_nxt = S_RTYPE_WB;
                end else begin
                    state_nxt     = S_FETCH;
                    illegal_set_c = 1'b1;
                end
            end
            S_RTYPE_WB: state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_ADDI:     state_nxt = S_ADDI_WB;
            S_ADDI_WB:  state_nxt = S_FETCH;
            S_JUMP:     state_nxt = S_FETCH;
            default:    state_nxt = S_RESET;
        endcase
    end

    // Moore output decode; fetch completion strobes wait for MemReady, branch PC load follows Zero.
    always_comb begin
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCEnable = 1'b0;
        PCSource = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        alu_code = ALU_AND;
        case (state)
            S_RESET:    PCSource = RESET_VECTOR_SEL;
            S_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = 2'b01;
                alu_code = ALU_ADD;
                IRWrite  = MemReady;
                PCEnable = MemReady;
            end
            S_DECODE: begin
                ALUSrcB  = 2'b11;
                alu_code = ALU_ADD;
            end
            S_MEMADDR, S_ADDI: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                alu_code = ALU_ADD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_RTYPE: begin
                ALUSrcA  = 1'b1;
                alu_code = funct_ctrl_c;
            end
            S_RTYPE_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                alu_code = ALU_SUB;
                PCSource = 2'b01;
                PCEnable = (OpCode == OP_BNE) ? ~Zero : Zero;
            end
            S_ADDI_WB:  RegWrite = 1'b1;
            S_JUMP: begin
                PCSource = 2'b10;
                PCEnable = 1'b1;
            end
            default: ;
        endcase
        // An instruction interrupted by Reset must not commit anything in that cycle.
        if (Reset) begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCEnable = 1'b0;
            RegWrite = 1'b0;
        end
        Control = ALU_W'(alu_code);
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench: per-instruction expected cycle traces built from the instruction semantics.
module tb_mips_multicycle_ctrl;

    logic       Clk;
    logic       Reset;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       MemRead, MemWrite, IorD, IRWrite, PCEnable;
    logic [1:0] PCSource;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] Control;
    logic       RegDst, MemtoReg, RegWrite, IllegalOp;

    mips_multicycle_ctrl #(.RESET_VECTOR_SEL(2'b00), .ALU_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCEnable(PCEnable), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .Control(Control), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .IllegalOp(IllegalOp)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       mr, mw, iord, irw, pce;
        logic [1:0] pcs;
        logic       asa;
        logic [1:0] asb;
        logic [3:0] ctl;
        logic       rdst, m2r, rw;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  rdy;
        logic  zero;
        logic  set_ill;
    } entry_t;

    localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010,
                           A_SUB = 4'b0110, A_SLT = 4'b0111;

    entry_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    logic   ill_model = 1'b0;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t blank();
        outs_t o;
        o = '0;
        return o;
    endfunction

    function automatic outs_t observed();
        outs_t o;
        o.mr = MemRead;  o.mw = MemWrite; o.iord = IorD; o.irw = IRWrite; o.pce = PCEnable;
        o.pcs = PCSource; o.asa = ALUSrcA; o.asb = ALUSrcB; o.ctl = Control;
        o.rdst = RegDst; o.m2r = MemtoReg; o.rw = RegWrite;
        return o;
    endfunction

    // {supported, ALU code} for an R-type funct field.
    function automatic logic [4:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return {1'b1, A_ADD};
            6'b100010: return {1'b1, A_SUB};
            6'b100100: return {1'b1, A_AND};
            6'b100101: return {1'b1, A_OR};
            6'b101010: return {1'b1, A_SLT};
            default:   return {1'b0, A_ADD};
        endcase
    endfunction

    function automatic void push(input outs_t o, input logic rdy, input logic z, input logic si);
        entry_t e;
        e.o = o; e.rdy = rdy; e.zero = z; e.set_ill = si;
        exp_q.push_back(e);
    endfunction

    function automatic outs_t fetch_o(input logic rdy);
        outs_t o;
        o = blank(); o.mr = 1'b1; o.asb = 2'b01; o.ctl = A_ADD; o.irw = rdy; o.pce = rdy;
        return o;
    endfunction

    // Expected per-cycle trace of one instruction, fw fetch stalls and mw data-access stalls.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fw, input int mw);
        outs_t      o;
        logic [4:0] fd;
        logic       legal;
        exp_q.delete();
        for (int i = 0; i < fw; i++) push(fetch_o(1'b0), 1'b0, rbit(), 1'b0);
        push(fetch_o(1'b1), 1'b1, rbit(), 1'b0);
        legal = op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                           6'b000101, 6'b001000, 6'b000010};
        o = blank(); o.asb = 2'b11; o.ctl = A_ADD;
        push(o, rbit(), rbit(), !legal);
        case (op)
            6'b000000: begin
                fd = funct_alu(fn);
                o = blank(); o.asa = 1'b1; o.ctl = fd[3:0];
                push(o, rbit(), rbit(), !fd[4]);
                if (fd[4]) begin
                    o = blank(); o.rw = 1'b1; o.rdst = 1'b1;
                    push(o, rbit(), rbit(), 1'b0);
                end
            end
            6'b100011, 6'b101011: begin
                o = blank(); o.asa = 1'b1; o.asb = 2'b10; o.ctl = A_ADD;
                push(o, rbit(), rbit(), 1'b0);
                o = blank(); o.iord = 1'b1;
                if (op == 6'b100011) o.mr = 1'b1; else o.mw = 1'b1;
                for (int i = 0; i < mw; i++) push(o, 1'b0, rbit(), 1'b0);
                push(o, 1'b1, rbit(), 1'b0);
                if (op == 6'b100011) begin
                    o = blank(); o.rw = 1'b1; o.m2r = 1'b1;
                    push(o, rbit(), rbit(), 1'b0);
                end
            end
            6'b000100, 6'b000101: begin
                o = blank(); o.asa = 1'b1; o.ctl = A_SUB; o.pcs = 2'b01;
                o.pce = (op == 6'b000100) ? z : ~z;
                push(o, rbit(), z, 1'b0);
            end
            6'b001000: begin
                o = blank(); o.asa = 1'b1; o.asb = 2'b10; o.ctl = A_ADD;
                push(o, rbit(), rbit(), 1'b0);
                o = blank(); o.rw = 1'b1;
                push(o, rbit(), rbit(), 1'b0);
            end
            6'b000010: begin
                o = blank(); o.pcs = 2'b10; o.pce = 1'b1;
                push(o, rbit(), rbit(), 1'b0);
            end
            default: ;
        endcase
    endtask

    // Drive one instruction (at most limit cycles) and compare every cycle.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fw, input int mw, input int limit);
        entry_t e;
        outs_t  obs;
        build(op, fn, z, fw, mw);
        for (int i = 0; i < exp_q.size() && i < limit; i++) begin
            e = exp_q[i];
            @(negedge Clk);
            OpCode = op; Funct = fn; MemReady = e.rdy; Zero = e.zero;
            #1;
            obs = observed();
            checks++;
            if (obs !== e.o) begin
                errors++;
                $display("FAIL %s cyc %0d outputs got %h want %h", name, i, obs, e.o);
            end
            checks++;
            if (IllegalOp !== ill_model) begin
                errors++;
                $display("FAIL %s cyc %0d IllegalOp got %b want %b", name, i, IllegalOp, ill_model);
            end
            if (e.set_ill) ill_model = 1'b1;
        end
    endtask

    // Two reset cycles then one S_RESET cycle with Reset low; next edge enters fetch.
    task automatic do_reset(input string name);
        outs_t rst_o;
        rst_o = blank();
        @(negedge Clk);
        Reset = 1'b1; MemReady = 1'b0;
        #1;
        checks++;
        if ({MemRead, MemWrite, IRWrite, PCEnable, RegWrite} !== 5'b0) begin
            errors++;
            $display("FAIL %s reset-cycle strobes got %b want 00000", name,
                     {MemRead, MemWrite, IRWrite, PCEnable, RegWrite});
        end
        @(negedge Clk);
        MemReady = rbit();
        #1;
        checks++;
        if (observed() !== rst_o || IllegalOp !== 1'b0) begin
            errors++;
            $display("FAIL %s in-reset outputs got %h/%b want %h/0", name, observed(), IllegalOp, rst_o);
        end
        @(negedge Clk);
        Reset = 1'b0; MemReady = rbit();
        #1;
        checks++;
        if (observed() !== rst_o) begin
            errors++;
            $display("FAIL %s S_RESET outputs got %h want %h", name, observed(), rst_o);
        end
        ill_model = 1'b0;
    endtask

    task automatic test_reset();
        do_reset("reset");
        run_instr("first_fetch_j", 6'b000010, 6'b000000, 1'b0, 1, 0, 100);
    endtask

    task automatic test_branch();
        run_instr("beq_nt", 6'b000100, 6'b000000, 1'b0, 0, 0, 100);
        run_instr("beq_t",  6'b000100, 6'b000000, 1'b1, 0, 0, 100);
        run_instr("bne_nt", 6'b000101, 6'b000000, 1'b1, 0, 0, 100);
        run_instr("bne_t",  6'b000101, 6'b000000, 1'b0, 2, 0, 100);
    endtask

    task automatic test_mem();
        run_instr("lw_stall2", 6'b100011, 6'b000000, 1'b0, 0, 2, 100);
        run_instr("lw_nostall", 6'b100011, 6'b000000, 1'b0, 0, 0, 100);
        run_instr("sw_stall1", 6'b101011, 6'b000000, 1'b0, 1, 1, 100);
    endtask

    task automatic test_rtype();
        run_instr("r_sub", 6'b000000, 6'b100010, 1'b0, 0, 0, 100);
        run_instr("r_slt", 6'b000000, 6'b101010, 1'b0, 0, 0, 100);
        run_instr("addi",  6'b001000, 6'b000000, 1'b0, 0, 0, 100);
        run_instr("r_bad", 6'b000000, 6'b111111, 1'b0, 0, 0, 100);
        run_instr("r_and_after_bad", 6'b000000, 6'b100100, 1'b0, 0, 0, 100);
        do_reset("reset_after_bad_funct");
    endtask

    task automatic test_jump_illegal();
        run_instr("j",      6'b000010, 6'b000000, 1'b0, 0, 0, 100);
        run_instr("bad_op", 6'b111111, 6'b000000, 1'b0, 0, 0, 100);
        run_instr("or_sticky", 6'b000000, 6'b100101, 1'b0, 0, 0, 100);
        do_reset("reset_clears_illegal");
        run_instr("add_clean", 6'b000000, 6'b100000, 1'b0, 0, 0, 100);
    endtask

    task automatic test_reset_mid_store();
        run_instr("sw_abort", 6'b101011, 6'b000000, 1'b0, 0, 5, 4);
        do_reset("reset_in_memwr");
        run_instr("addi_resume", 6'b001000, 6'b000000, 1'b0, 0, 0, 100);
    endtask

    task automatic test_random();
        logic [5:0] ops[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                               6'b000101, 6'b001000, 6'b000010};
        logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [5:0] op, fn;
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr("random", op, fn, rbit(), $urandom_range(0, 2), $urandom_range(0, 2), 100);
        end
        do_reset("reset_end");
    endtask

    initial begin
        Reset = 1'b1; MemReady = 1'b0; Zero = 1'b0; OpCode = '0; Funct = '0;
        test_reset();
        test_branch();
        test_mem();
        test_rtype();
        test_jump_illegal();
        test_reset_mid_store();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
